// File: rtl/counter_scoreboard_if.sv
// -----------------------------------------------------------------------------
// counter_scoreboard_if
//   Bundles the event inputs and the score/status outputs of the scoreboard.
//
//   Signals:
//     winner, loser          event levels coming from the up/down counter
//     win_count, lose_count  tallies for the current game (4 bits each)
//     game_over              high while the game is finished
//     game_winner            1 = winner side reached the limit, 0 = loser side
//     collision              one-cycle pulse when both events arrive together
//
//   Modports:
//     master  drives winner/loser and observes the results (counter side / bench)
//     slave   the scoreboard itself
// -----------------------------------------------------------------------------
interface counter_scoreboard_if;
    logic       winner;
    logic       loser;
    logic [3:0] win_count;
    logic [3:0] lose_count;
    logic       game_over;
    logic       game_winner;
    logic       collision;

    modport master (
        output winner,
        output loser,
        input  win_count,
        input  lose_count,
        input  game_over,
        input  game_winner,
        input  collision
    );

    modport slave (
        input  winner,
        input  loser,
        output win_count,
        output lose_count,
        output game_over,
        output game_winner,
        output collision
    );
endinterface

// File: rtl/counter_scoreboard.sv
// -----------------------------------------------------------------------------
// counter_scoreboard
//   Tallies rising edges of the counter's winner/loser indications. When either
//   tally reaches WIN_LIMIT the game is declared over and the scores freeze.
//
//   Ports:
//     clk      single clock, rising edge
//     reset    synchronous, active-high; returns every output to zero
//     sb       counter_scoreboard_if.slave
//                in : winner, loser
//                out: win_count, lose_count, game_over, game_winner, collision
//
//   Parameters:
//     WIN_LIMIT    score that ends a game (1..15)
//     HOLD_CYCLES  cycles spent in OVER before auto-restart (1..255),
//                  only meaningful with GAME_RESTART_EN
//
//   Optional feature (macro GAME_RESTART_EN):
//     Defined     -> OVER lasts HOLD_CYCLES cycles, then counts clear and a new
//                    game starts; game_winner keeps the last result.
//     Not defined -> OVER is terminal until reset; no hold counter is built.
// -----------------------------------------------------------------------------
module counter_scoreboard #(
    parameter int WIN_LIMIT   = 15,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_scoreboard_if.slave  sb
);

    // Elaboration-time parameter range checks.
    if (WIN_LIMIT < 1 || WIN_LIMIT > 15) begin : g_bad_win_limit
        $error("counter_scoreboard: WIN_LIMIT must be in 1..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
        $error("counter_scoreboard: HOLD_CYCLES must be in 1..255");
    end

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(WIN_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_winner_q;
    logic       r_loser_q;
    logic       w_win_ev;
    logic       w_lose_ev;

    logic [3:0] r_win_count;
    logic [3:0] w_win_count_nxt;
    logic [3:0] r_lose_count;
    logic [3:0] w_lose_count_nxt;
    logic       r_game_winner;
    logic       w_game_winner_nxt;
    logic       r_collision;
    logic       w_collision_nxt;

`ifdef GAME_RESTART_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
`endif

    // Edge detect runs in every state, so a level that is still high when a
    // game (re)starts is never mistaken for a fresh event.
    assign w_win_ev  = sb.winner & ~r_winner_q;
    assign w_lose_ev = sb.loser  & ~r_loser_q;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_win_count_nxt   = r_win_count;
        w_lose_count_nxt  = r_lose_count;
        w_game_winner_nxt = r_game_winner;
        w_collision_nxt   = 1'b0;
`ifdef GAME_RESTART_EN
        // Held at zero during PLAY so it starts from 0 on entry to OVER.
        w_hold_nxt        = '0;
`endif

        case (r_state)
            PLAY: begin
                if (w_win_ev && w_lose_ev) begin
                    // Simultaneous events cancel: flag it, score nothing.
                    w_collision_nxt = 1'b1;
                end else if (w_win_ev) begin
                    w_win_count_nxt = r_win_count + 4'd1;
                    if (r_win_count + 4'd1 == LIMIT) begin
                        w_state_nxt       = OVER;
                        w_game_winner_nxt = 1'b1;
                    end
                end else if (w_lose_ev) begin
                    w_lose_count_nxt = r_lose_count + 4'd1;
                    if (r_lose_count + 4'd1 == LIMIT) begin
                        w_state_nxt       = OVER;
                        w_game_winner_nxt = 1'b0;
                    end
                end
            end

            OVER: begin
`ifdef GAME_RESTART_EN
                // Leave OVER on the edge after the last hold cycle, so
                // game_over is high for exactly HOLD_CYCLES cycles.
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt      = PLAY;
                    w_win_count_nxt  = '0;
                    w_lose_count_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
`endif
            end

            default: begin
                w_state_nxt = PLAY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= PLAY;
            r_winner_q    <= 1'b0;
            r_loser_q     <= 1'b0;
            r_win_count   <= '0;
            r_lose_count  <= '0;
            r_game_winner <= 1'b0;
            r_collision   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_winner_q    <= sb.winner;
            r_loser_q     <= sb.loser;
            r_win_count   <= w_win_count_nxt;
            r_lose_count  <= w_lose_count_nxt;
            r_game_winner <= w_game_winner_nxt;
            r_collision   <= w_collision_nxt;
        end
    end

`ifdef GAME_RESTART_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`endif

    assign sb.win_count   = r_win_count;
    assign sb.lose_count  = r_lose_count;
    assign sb.game_over   = (r_state == OVER);
    assign sb.game_winner = r_game_winner;
    assign sb.collision   = r_collision;

endmodule

// File: tb/tb_counter_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_counter_scoreboard
//   Self-checking bench for counter_scoreboard: a vector table, hand-written
//   game sequences, and a randomized run compared against a behavioural model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_scoreboard;

    localparam int WL = 15;
    localparam int HC = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    counter_scoreboard_if u_if();

    counter_scoreboard #(
        .WIN_LIMIT   (WL),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state (game-level view of the scoreboard).
    int m_win, m_lose, m_hold;
    bit m_over, m_gw, m_coll, m_wprev, m_lprev;

    typedef struct {
        bit rst;
        bit w;
        bit l;
        int win;
        int lose;
        bit go;
        bit gw;
        bit coll;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int win, input int lose,
                             input int go, input int gw, input int coll);
        check({tag, ".win_count"},   int'(u_if.win_count),   win);
        check({tag, ".lose_count"},  int'(u_if.lose_count),  lose);
        check({tag, ".game_over"},   int'(u_if.game_over),   go);
        check({tag, ".game_winner"}, int'(u_if.game_winner), gw);
        check({tag, ".collision"},   int'(u_if.collision),   coll);
    endtask

    // One clock edge as seen by the game rules.
    task automatic model_step(input bit r, input bit w, input bit l);
        bit we, le;
        if (r) begin
            m_win = 0; m_lose = 0; m_hold = 0;
            m_over = 0; m_gw = 0; m_coll = 0;
            m_wprev = 0; m_lprev = 0;
        end else begin
            we = w && !m_wprev;
            le = l && !m_lprev;
            m_coll = 0;
            if (!m_over) begin
                if (we && le) begin
                    m_coll = 1;
                end else if (we) begin
                    m_win++;
                    if (m_win == WL) begin m_over = 1; m_gw = 1; m_hold = 0; end
                end else if (le) begin
                    m_lose++;
                    if (m_lose == WL) begin m_over = 1; m_gw = 0; m_hold = 0; end
                end
            end else begin
`ifdef GAME_RESTART_EN
                if (m_hold == HC - 1) begin
                    m_over = 0; m_win = 0; m_lose = 0;
                end else begin
                    m_hold++;
                end
`endif
            end
            m_wprev = w;
            m_lprev = l;
        end
    endtask

    // Apply inputs for one cycle; outputs are sampled 1 ns after the edge.
    task automatic cyc(input bit r, input bit w, input bit l);
        reset       = r;
        u_if.winner = w;
        u_if.loser  = l;
        @(posedge clk);
        model_step(r, w, l);
        #1;
    endtask

    task automatic pulse_w();
        cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    task automatic pulse_l();
        cyc(0, 0, 1);
        cyc(0, 0, 0);
    endtask

    initial begin
        reset       = 1'b1;
        u_if.winner = 1'b0;
        u_if.loser  = 1'b0;

        // ---------------- vector table ----------------
        //          rst w  l  win lose go gw coll
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0, 0, 1};  // history cleared by reset: both rise
        tbl[3]  = '{0, 1, 1, 0, 0, 0, 0, 0};  // held level, no new event
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 2, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 2, 1, 0, 0, 0};
        tbl[11] = '{0, 1, 1, 2, 1, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 2, 1, 0, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 0, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst, tbl[i].w, tbl[i].l);
            check_all($sformatf("vec%0d", i), tbl[i].win, tbl[i].lose,
                      tbl[i].go, tbl[i].gw, tbl[i].coll);
        end

        // ---------------- 15 winner pulses, 3 cycles apart ----------------
        cyc(1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 1, 0);
            check($sformatf("ramp%0d.win_count", i), int'(u_if.win_count), i);
            check($sformatf("ramp%0d.game_over", i), int'(u_if.game_over), (i == 15) ? 1 : 0);
            cyc(0, 0, 0);
            cyc(0, 0, 0);
        end
        check("ramp.lose_count",  int'(u_if.lose_count),  0);
        check("ramp.game_winner", int'(u_if.game_winner), 1);
        check("ramp.game_over_hold", int'(u_if.game_over), 1);

        // ---------------- held levels count once ----------------
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0);
            check("held.collision", int'(u_if.collision), 0);
        end
        cyc(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0);
            check("held2.collision", int'(u_if.collision), 0);
        end
        cyc(0, 0, 0);
        check("held.win_count", int'(u_if.win_count), 2);
        check("held.collision_end", int'(u_if.collision), 0);

        // ---------------- collision at 3/5 ----------------
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) pulse_w();
        for (int i = 0; i < 5; i++) pulse_l();
        cyc(0, 1, 1);
        check_all("coll", 3, 5, 0, 0, 1);
        cyc(0, 0, 0);
        check_all("coll_after", 3, 5, 0, 0, 0);

        // ---------------- loser side wins, scores freeze ----------------
        cyc(1, 0, 0);
        for (int i = 0; i < 2; i++) pulse_w();
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1);
            if (i == 15) check_all("lose15", 2, 15, 1, 0, 0);
            cyc(0, 0, 0);
        end
`ifndef GAME_RESTART_EN
        for (int i = 0; i < 4; i++) pulse_w();
        for (int i = 0; i < 2; i++) pulse_l();
        check_all("frozen", 2, 15, 1, 0, 0);
        cyc(0, 1, 1);
        check_all("frozen_nocoll", 2, 15, 1, 0, 0);
`endif
        cyc(1, 0, 0);
        check_all("post_reset", 0, 0, 0, 0, 0);

`ifdef GAME_RESTART_EN
        // ---------------- auto-restart after HOLD_CYCLES ----------------
        cyc(1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 1, 0);
            if (i < 15) cyc(0, 0, 0);
        end
        check_all("rs_over1", 15, 0, 1, 1, 0);
        cyc(0, 0, 0);
        check_all("rs_over2", 15, 0, 1, 1, 0);
        cyc(0, 0, 0);
        check_all("rs_over3", 15, 0, 1, 1, 0);
        cyc(0, 0, 0);
        check_all("rs_over4", 15, 0, 1, 1, 0);
        cyc(0, 0, 0);
        check_all("rs_restart", 0, 0, 0, 1, 0);
        cyc(0, 1, 0);
        check_all("rs_newgame", 1, 0, 0, 1, 0);
        cyc(0, 0, 0);
`endif

        // ---------------- randomized run against the model ----------------
        cyc(1, 0, 0);
        check_all("rand_reset", m_win, m_lose, int'(m_over), int'(m_gw), int'(m_coll));
        for (int i = 0; i < 3000; i++) begin
            bit r, w, l;
            r = ($urandom_range(0, 149) == 0);
            w = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 2) == 0);
            cyc(r, w, l);
            check_all($sformatf("rand%0d", i), m_win, m_lose,
                      int'(m_over), int'(m_gw), int'(m_coll));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
